// File: rtl/mem_arbiter.sv
// Two-client arbiter in front of the byte-serial memory controller.
// The load/store client wins ties; an aging counter forces a fetch grant
// after STARVE_LIMIT consecutive load/store grants made while a fetch waits.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_len,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        mem_valid,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_len,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_LS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    logic             grant_ls;
    logic             grant_if;
    logic             abort;

    // Arbitration, abort and completion decode from the current state.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        grant_ls = 1'b0;
        grant_if = 1'b0;
        abort    = 1'b0;
        if (state == IDLE) begin
            grant_ls = ls_req && (!if_req || (starve_cnt < LIMIT) || clear);
            grant_if = !grant_ls && if_req && !clear;
        end
        case (state)
            GNT_IF:  abort = clear || !if_req;
            GNT_LS:  abort = !mem_wr && !ls_req;  // stores always run to completion
            default: abort = 1'b0;
        endcase
        mem_valid = (state != IDLE) && !mem_done && !abort;
        if_done   = (state == GNT_IF) && mem_done && !clear;
        ls_done   = (state == GNT_LS) && mem_done;
        if_data   = mem_rdata;
        ls_rdata  = mem_rdata;
        busy      = (state != IDLE);
    end

    // Next state and next starvation count.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (grant_ls)      state_nxt = GNT_LS;
                else if (grant_if) state_nxt = GNT_IF;
            end
            GNT_IF, GNT_LS: begin
                if (mem_done || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (grant_if) begin
            starve_nxt = '0;
        end else if (grant_ls && if_req) begin
            if (starve_cnt < LIMIT) starve_nxt = starve_cnt + CNT_W'(1);
        end else if (state == IDLE && !if_req) begin
            starve_nxt = '0;
        end
    end

    // State and aging counter; everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else if (rdy) begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Request field registers, loaded from the winning client at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_len   <= '0;
        end else if (rdy) begin
            if (grant_ls) begin
                mem_wr    <= ls_wr;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
                mem_len   <= ls_len;
            end else if (grant_if) begin
                mem_wr   <= 1'b0;
                mem_addr <= if_addr;
                mem_len  <= 3'd4;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed client/controller stimulus,
// with expected grants and completions queued and matched by monitors.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [2:0]  ls_len = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        mem_valid;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_len;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  len;
    } grant_t;

    typedef struct packed {
        logic        is_ls;
        logic [31:0] data;
    } done_t;

    grant_t grant_q[$];
    done_t  done_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    logic   busy_q = 1'b0;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_len(ls_len), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: a new grant shows up as busy rising.
    always @(negedge clk) begin
        if (rst_n && busy && !busy_q) begin
            if (grant_q.size() == 0) begin
                check("unexpected_grant", 64'd1, 64'd0);
            end else begin
                grant_t g;
                g = grant_q.pop_front();
                check("grant_wr", 64'(mem_wr), 64'(g.wr));
                check("grant_addr", 64'(mem_addr), 64'(g.addr));
                check("grant_len", 64'(mem_len), 64'(g.len));
                if (g.wr) check("grant_wdata", 64'(mem_wdata), 64'(g.wdata));
            end
        end
        if (rst_n && (if_done || ls_done)) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", {62'd0, if_done, ls_done}, 64'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("done_if", 64'(if_done), 64'(!d.is_ls));
                check("done_ls", 64'(ls_done), 64'(d.is_ls));
                check("done_data", 64'(d.is_ls ? ls_rdata : if_data), 64'(d.data));
            end
        end
        busy_q = rst_n ? busy : 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic grant_t ls_grant(input logic wr, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [2:0] l);
        grant_t g;
        g.wr = wr; g.addr = a; g.wdata = wd; g.len = l;
        return g;
    endfunction

    // Controller reports completion for one cycle; done pulse checked mid-cycle.
    task automatic complete(input logic is_ls, input logic [31:0] data);
        done_t d;
        d.is_ls = is_ls; d.data = data;
        done_q.push_back(d);
        mem_rdata = data;
        mem_done  = 1'b1;
        @(negedge clk);
        check("valid_low_on_done", 64'(mem_valid), 64'd0);
        step();
        mem_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fields", {mem_wr, mem_addr, mem_len}, 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_dones", {if_done, ls_done}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1. fetch only
        if_req = 1'b1; if_addr = 32'h100;
        grant_q.push_back(ls_grant(1'b0, 32'h100, 32'h0, 3'd4));
        step();
        @(negedge clk);
        check("t1_valid", 64'(mem_valid), 64'd1);
        repeat (4) step();
        complete(1'b0, 32'hDEADBEEF);
        if_req = 1'b0;
        @(negedge clk);
        check("t1_idle", 64'(busy), 64'd0);
        step();

        // 2. simultaneous requests: load wins, fetch after one idle cycle
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h20; ls_len = 3'd2;
        grant_q.push_back(ls_grant(1'b0, 32'h20, 32'h0, 3'd2));
        grant_q.push_back(ls_grant(1'b0, 32'h200, 32'h0, 3'd4));
        step();
        step();
        complete(1'b1, 32'h0000_1234);
        ls_req = 1'b0;
        @(negedge clk);
        check("t2_gap_idle", 64'(busy), 64'd0);
        step();
        @(negedge clk);
        check("t2_if_busy", 64'(busy), 64'd1);
        check("t2_cnt_after_if", 64'(dut.starve_cnt), 64'd0);
        step();
        complete(1'b0, 32'hCAFE_0002);
        if_req = 1'b0;
        step();

        // 3. starvation: four loads, then the fetch is forced
        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'd4;
        for (int k = 0; k < 4; k++) begin
            ls_addr = 32'h40 + 32'(k * 4);
            grant_q.push_back(ls_grant(1'b0, ls_addr, 32'h0, 3'd4));
            step();
            step();
            complete(1'b1, 32'hA000_0000 + 32'(k));
        end
        @(negedge clk);
        check("t3_cnt_saturated", 64'(dut.starve_cnt), 64'd4);
        grant_q.push_back(ls_grant(1'b0, 32'h300, 32'h0, 3'd4));
        step();
        ls_req = 1'b0;
        @(negedge clk);
        check("t3_if_forced", 64'(mem_len), 64'd4);
        check("t3_cnt_cleared", 64'(dut.starve_cnt), 64'd0);
        step();
        complete(1'b0, 32'h1F1F_0003);
        if_req = 1'b0;
        step();

        // 4. clear aborts a fetch
        if_req = 1'b1; if_addr = 32'h400;
        grant_q.push_back(ls_grant(1'b0, 32'h400, 32'h0, 3'd4));
        step();
        step();
        clear = 1'b1;
        @(negedge clk);
        check("t4_valid_abort", 64'(mem_valid), 64'd0);
        check("t4_no_done", 64'(if_done), 64'd0);
        step();
        clear = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check("t4_idle", 64'(busy), 64'd0);
        step();

        // 5. store survives clear and request drop
        ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_wdata = 32'h41; ls_len = 3'd1;
        grant_q.push_back(ls_grant(1'b1, 32'h30000, 32'h41, 3'd1));
        step();
        step();
        ls_req = 1'b0; clear = 1'b1;
        @(negedge clk);
        check("t5_valid_held", 64'(mem_valid), 64'd1);
        step();
        clear = 1'b0;
        @(negedge clk);
        check("t5_valid_held2", 64'(mem_valid), 64'd1);
        step();
        complete(1'b1, 32'h0);
        ls_wr = 1'b0;
        @(negedge clk);
        check("t5_idle", 64'(busy), 64'd0);
        step();

        // 6. rdy low freezes a load grant, then async reset mid-grant
        ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h50; ls_len = 3'd4;
        grant_q.push_back(ls_grant(1'b0, 32'h50, 32'h0, 3'd4));
        step();
        rdy = 1'b0;
        ls_addr = 32'h9999;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_frozen_busy", 64'(busy), 64'd1);
            check("t6_frozen_valid", 64'(mem_valid), 64'd1);
            check("t6_frozen_addr", 64'(mem_addr), 64'h50);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(mem_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_addr", 64'(mem_addr), 64'd0);
        ls_req = 1'b0; rdy = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        check("grant_q_drained", 64'(grant_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
